// File: rtl/cfs_rx_ctrl_pkg.sv
// Shared definitions for the multi-channel MD RX controller:
// derived widths, push_data field positions and the transfer legality rule.
package cfs_rx_ctrl_pkg;

    // Data field always sits at the bottom of push_data.
    localparam int PUSH_DATA_LSB = 0;

    // Width of the offset field for a data word of the given byte count.
    function automatic int calc_offset_w(input int bytes);
        return (bytes <= 1) ? 1 : $clog2(bytes);
    endfunction

    // Width of the size field; one extra bit so a full-word size fits.
    function automatic int calc_size_w(input int bytes);
        return $clog2(bytes) + 1;
    endfunction

    // Width of a channel index, never narrower than one bit.
    function automatic int calc_ch_w(input int num_ch);
        return (num_ch <= 1) ? 1 : $clog2(num_ch);
    endfunction

    // push_data is {ch, size, offset, data}, MSB to LSB.
    function automatic int field_offset_lsb(input int data_w);
        return PUSH_DATA_LSB + data_w;
    endfunction

    function automatic int field_offset_msb(input int data_w);
        return field_offset_lsb(data_w) + calc_offset_w(data_w / 8) - 1;
    endfunction

    function automatic int field_size_lsb(input int data_w);
        return field_offset_msb(data_w) + 1;
    endfunction

    function automatic int field_size_msb(input int data_w);
        return field_size_lsb(data_w) + calc_size_w(data_w / 8) - 1;
    endfunction

    function automatic int field_ch_lsb(input int data_w);
        return field_size_msb(data_w) + 1;
    endfunction

    function automatic int field_ch_msb(input int data_w, input int num_ch);
        return field_ch_lsb(data_w) + calc_ch_w(num_ch) - 1;
    endfunction

    // A transfer is illegal when its size is zero, when the end of the word
    // (bytes + offset) is not a multiple of size, or, with the bound check
    // enabled, when it runs past the data word. Operands are zero-extended
    // into int, so the sum and the modulo never truncate.
    function automatic logic rx_transfer_illegal(input int bytes,
                                                 input int offset,
                                                 input int size,
                                                 input bit bound_en);
        logic bad;
        bad = 1'b0;
        if (size == 0) begin
            bad = 1'b1;
        end else begin
            if (((bytes + offset) % size) != 0) begin
                bad = 1'b1;
            end
            if (bound_en && ((offset + size) > bytes)) begin
                bad = 1'b1;
            end
        end
        return bad;
    endfunction

endpackage

// File: rtl/cfs_rr_arbiter.sv
// Round-robin arbiter: grants the first requester after the last accepted
// channel, wrapping from NUM_CH-1 back to 0. The pointer only moves when the
// caller reports that the grant was taken (advance).
module cfs_rr_arbiter
    import cfs_rx_ctrl_pkg::*;
#(
    parameter int NUM_CH = 2,
    localparam int CH_W  = calc_ch_w(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] req,
    input  logic              advance,
    output logic [NUM_CH-1:0] grant_onehot,
    output logic [CH_W-1:0]   grant_idx
);

    logic [CH_W-1:0] ptr;
    logic            any_grant;

    // Two ordered passes: first the channels above the pointer, then the rest.
    always_comb begin
        grant_onehot = '0;
        grant_idx    = '0;
        any_grant    = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (!any_grant && req[c] && (c > int'(ptr))) begin
                any_grant       = 1'b1;
                grant_onehot[c] = 1'b1;
                grant_idx       = CH_W'(c);
            end
        end
        for (int c = 0; c < NUM_CH; c++) begin
            if (!any_grant && req[c] && (c <= int'(ptr))) begin
                any_grant       = 1'b1;
                grant_onehot[c] = 1'b1;
                grant_idx       = CH_W'(c);
            end
        end
    end

    // Pointer starts at the last channel so channel 0 wins first after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= CH_W'(NUM_CH - 1);
        end else if (advance && any_grant) begin
            ptr <= grant_idx;
        end
    end

endmodule

// File: rtl/cfs_rx_ctrl_mc.sv
// Multi-channel MD RX controller. Each channel's request is checked for
// alignment legality; illegal requests are acknowledged at once and counted,
// legal ones are round-robin arbitrated into a single registered push stage.
// Optional build macro CFS_RX_CTRL_MC_SIZE_BOUND_EN additionally rejects
// transfers whose offset+size runs past the data word.
module cfs_rx_ctrl_mc
    import cfs_rx_ctrl_pkg::*;
#(
    parameter int NUM_CH                = 2,
    parameter int ALGN_DATA_WIDTH       = 32,
    parameter int STATUS_CNT_DROP_WIDTH = 8,
    localparam int BYTES           = ALGN_DATA_WIDTH / 8,
    localparam int CH_WIDTH        = calc_ch_w(NUM_CH),
    localparam int OFFSET_W        = calc_offset_w(BYTES),
    localparam int SIZE_W          = calc_size_w(BYTES),
    localparam int FIFO_DATA_WIDTH = CH_WIDTH + SIZE_W + OFFSET_W + ALGN_DATA_WIDTH
) (
    input  logic                                    pclk,
    input  logic                                    preset_n,
    input  logic [NUM_CH-1:0]                       clr_cnt_drop,
    output logic [NUM_CH*STATUS_CNT_DROP_WIDTH-1:0] status_cnt_drop,
    input  logic [NUM_CH-1:0]                       md_rx_valid,
    input  logic [NUM_CH*ALGN_DATA_WIDTH-1:0]       md_rx_data,
    input  logic [NUM_CH*OFFSET_W-1:0]              md_rx_offset,
    input  logic [NUM_CH*SIZE_W-1:0]                md_rx_size,
    output logic [NUM_CH-1:0]                       md_rx_ready,
    output logic [NUM_CH-1:0]                       md_rx_err,
    output logic                                    push_valid,
    output logic [FIFO_DATA_WIDTH-1:0]              push_data,
    input  logic                                    push_ready
);

`ifdef CFS_RX_CTRL_MC_SIZE_BOUND_EN
    localparam bit BOUND_EN = 1'b1;
`else
    localparam bit BOUND_EN = 1'b0;
`endif

    localparam int OFFSET_LSB = field_offset_lsb(ALGN_DATA_WIDTH);
    localparam int OFFSET_MSB = field_offset_msb(ALGN_DATA_WIDTH);
    localparam int SIZE_LSB   = field_size_lsb(ALGN_DATA_WIDTH);
    localparam int SIZE_MSB   = field_size_msb(ALGN_DATA_WIDTH);
    localparam int CH_LSB     = field_ch_lsb(ALGN_DATA_WIDTH);
    localparam int CH_MSB     = field_ch_msb(ALGN_DATA_WIDTH, NUM_CH);

    logic [NUM_CH-1:0]                err;
    logic [NUM_CH-1:0]                legal;
    logic [NUM_CH-1:0]                grant_onehot;
    logic [CH_WIDTH-1:0]              grant_idx;
    logic                             load;
    logic                             accept;
    logic [ALGN_DATA_WIDTH-1:0]       sel_data;
    logic [OFFSET_W-1:0]              sel_offset;
    logic [SIZE_W-1:0]                sel_size;
    logic [STATUS_CNT_DROP_WIDTH-1:0] cnt [NUM_CH];

    // Per-channel legality; only a valid request can be flagged illegal.
    always_comb begin
        err   = '0;
        legal = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            err[c]   = md_rx_valid[c] &
                       rx_transfer_illegal(BYTES,
                                           int'(md_rx_offset[c*OFFSET_W +: OFFSET_W]),
                                           int'(md_rx_size[c*SIZE_W +: SIZE_W]),
                                           BOUND_EN);
            legal[c] = md_rx_valid[c] & ~err[c];
        end
    end

    assign md_rx_err = err;

    // The output stage can take a new beat when empty or draining this cycle.
    assign load   = ~push_valid | push_ready;
    assign accept = load & (|legal);

    // Illegal requests are acked unconditionally; legal ones only when granted and loadable.
    assign md_rx_ready = err | (grant_onehot & {NUM_CH{load}});

    cfs_rr_arbiter #(
        .NUM_CH (NUM_CH)
    ) u_arbiter (
        .clk          (pclk),
        .rst_n        (preset_n),
        .req          (legal),
        .advance      (accept),
        .grant_onehot (grant_onehot),
        .grant_idx    (grant_idx)
    );

    // Steer the granted channel's fields toward the output register.
    always_comb begin
        sel_data   = '0;
        sel_offset = '0;
        sel_size   = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (grant_onehot[c]) begin
                sel_data   = md_rx_data[c*ALGN_DATA_WIDTH +: ALGN_DATA_WIDTH];
                sel_offset = md_rx_offset[c*OFFSET_W +: OFFSET_W];
                sel_size   = md_rx_size[c*SIZE_W +: SIZE_W];
            end
        end
    end

    // Registered push stage: load on acceptance, drop valid once drained, hold under backpressure.
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            push_valid <= 1'b0;
            push_data  <= '0;
        end else if (accept) begin
            push_valid                                     <= 1'b1;
            push_data[CH_MSB:CH_LSB]                       <= grant_idx;
            push_data[SIZE_MSB:SIZE_LSB]                   <= sel_size;
            push_data[OFFSET_MSB:OFFSET_LSB]               <= sel_offset;
            push_data[PUSH_DATA_LSB +: ALGN_DATA_WIDTH]    <= sel_data;
        end else if (push_ready) begin
            push_valid <= 1'b0;
        end
    end

    // Saturating per-channel drop counters; a clear wins over an increment.
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                cnt[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (clr_cnt_drop[c]) begin
                    cnt[c] <= '0;
                end else if (md_rx_valid[c] && md_rx_ready[c] && err[c] &&
                             (cnt[c] != {STATUS_CNT_DROP_WIDTH{1'b1}})) begin
                    cnt[c] <= cnt[c] + 1'b1;
                end
            end
        end
    end

    // Pack the counters onto the status bus, channel c at slice c.
    always_comb begin
        status_cnt_drop = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            status_cnt_drop[c*STATUS_CNT_DROP_WIDTH +: STATUS_CNT_DROP_WIDTH] = cnt[c];
        end
    end

endmodule

// File: tb/tb_cfs_rx_ctrl_mc.sv
// Self-checking bench for cfs_rx_ctrl_mc (NUM_CH=2, 32-bit data, 2-bit drop
// counters so saturation is reachable). Honours CFS_RX_CTRL_MC_SIZE_BOUND_EN.
module tb_cfs_rx_ctrl_mc;
    import cfs_rx_ctrl_pkg::*;

    localparam int NCH   = 2;
    localparam int DW    = 32;
    localparam int CW    = 2;
    localparam int BYTES = 4;
    localparam int FW    = 1 + 3 + 2 + DW;
    localparam int CMAX  = 3;

`ifdef CFS_RX_CTRL_MC_SIZE_BOUND_EN
    localparam bit BOUND = 1'b1;
`else
    localparam bit BOUND = 1'b0;
`endif

    logic              pclk;
    logic              preset_n;
    logic [NCH-1:0]    clr_cnt_drop;
    logic [NCH*CW-1:0] status_cnt_drop;
    logic [NCH-1:0]    md_rx_valid;
    logic [NCH*DW-1:0] md_rx_data;
    logic [NCH*2-1:0]  md_rx_offset;
    logic [NCH*3-1:0]  md_rx_size;
    logic [NCH-1:0]    md_rx_ready;
    logic [NCH-1:0]    md_rx_err;
    logic              push_valid;
    logic [FW-1:0]     push_data;
    logic              push_ready;

    int vectors;
    int miscompares;

    cfs_rx_ctrl_mc #(
        .NUM_CH                (NCH),
        .ALGN_DATA_WIDTH       (DW),
        .STATUS_CNT_DROP_WIDTH (CW)
    ) dut (
        .pclk            (pclk),
        .preset_n        (preset_n),
        .clr_cnt_drop    (clr_cnt_drop),
        .status_cnt_drop (status_cnt_drop),
        .md_rx_valid     (md_rx_valid),
        .md_rx_data      (md_rx_data),
        .md_rx_offset    (md_rx_offset),
        .md_rx_size      (md_rx_size),
        .md_rx_ready     (md_rx_ready),
        .md_rx_err       (md_rx_err),
        .push_valid      (push_valid),
        .push_data       (push_data),
        .push_ready      (push_ready)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    typedef struct {
        bit          valid;
        int          off;
        int          size;
        logic [31:0] data;
        bit          exp_err;
        bit          exp_ready;
    } vec_t;

    vec_t tbl [11];

    // Legality straight from the rules: nonzero size dividing BYTES+offset, optional bound.
    function automatic bit model_err(input int off, input int size);
        if (size == 0) return 1'b1;
        if (((BYTES + off) % size) != 0) return 1'b1;
        if (BOUND && ((off + size) > BYTES)) return 1'b1;
        return 1'b0;
    endfunction

    // Next channel after 'last' (wrapping) that has a legal request, or -1.
    function automatic int rr_pick(input logic [NCH-1:0] legal, input int last);
        int ch;
        for (int k = 1; k <= NCH; k++) begin
            ch = (last + k) % NCH;
            if (legal[ch]) return ch;
        end
        return -1;
    endfunction

    function automatic logic [FW-1:0] pack(input int ch, input int size, input int off,
                                          input logic [31:0] data);
        return {1'(ch), 3'(size), 2'(off), data};
    endfunction

    task automatic check_output(input string name, input logic [63:0] actual,
                                input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic apply_stimulus(input int c, input bit v, input int off, input int size,
                                  input logic [31:0] data);
        md_rx_valid[c]          = v;
        md_rx_offset[c*2 +: 2]  = 2'(off);
        md_rx_size[c*3 +: 3]    = 3'(size);
        md_rx_data[c*DW +: DW]  = data;
    endtask

    task automatic next_cycle();
        @(posedge pclk);
        #1;
    endtask

    task automatic pulse_reset();
        preset_n = 1'b0;
        md_rx_valid = '0;
        clr_cnt_drop = '0;
        #3;
        preset_n = 1'b1;
        next_cycle();
    endtask

    initial begin
        bit          r_v    [NCH];
        int          r_off  [NCH];
        int          r_size [NCH];
        logic [31:0] r_data [NCH];
        bit          pend   [NCH];
        int          m_cnt  [NCH];
        logic [NCH-1:0] e_err, e_legal, e_ready;
        logic [31:0] d [NCH];
        logic [FW-1:0] held;
        logic [FW-1:0] m_pd;
        bit          m_pv;
        bit          load;
        int          g;
        int          m_last;
        int          ecnt;
        int          exp_ch;

        vectors      = 0;
        miscompares  = 0;
        preset_n     = 1'b0;
        clr_cnt_drop = '0;
        md_rx_valid  = '0;
        md_rx_data   = '0;
        md_rx_offset = '0;
        md_rx_size   = '0;
        push_ready   = 1'b1;

        tbl[0]  = '{1'b1, 0, 0, 32'h1111_0000, 1'b1, 1'b1};
        tbl[1]  = '{1'b1, 1, 2, 32'h1111_0001, 1'b1, 1'b1};
        tbl[2]  = '{1'b1, 3, 2, 32'h1111_0002, 1'b1, 1'b1};
        tbl[3]  = '{1'b1, 2, 2, 32'h1111_0003, 1'b0, 1'b1};
        tbl[4]  = '{1'b1, 3, 1, 32'h1111_0004, 1'b0, 1'b1};
        tbl[5]  = '{1'b1, 2, 3, 32'h1111_0005, BOUND, 1'b1};
        tbl[6]  = '{1'b1, 0, 4, 32'h1111_0006, 1'b0, 1'b1};
        tbl[7]  = '{1'b1, 1, 1, 32'h1111_0007, 1'b0, 1'b1};
        tbl[8]  = '{1'b1, 0, 3, 32'h1111_0008, 1'b1, 1'b1};
        tbl[9]  = '{1'b1, 3, 4, 32'h1111_0009, 1'b1, 1'b1};
        tbl[10] = '{1'b0, 1, 0, 32'h1111_000A, 1'b0, 1'b0};

        // Reset state
        #12;
        check_output("reset push_valid", 64'(push_valid), 64'd0);
        check_output("reset push_data", 64'(push_data), 64'd0);
        check_output("reset counters", 64'(status_cnt_drop), 64'd0);
        @(negedge pclk);
        preset_n = 1'b1;
        next_cycle();

        // Package legality function against the plain-arithmetic rule
        for (int off = 0; off < 4; off++) begin
            for (int size = 0; size < 8; size++) begin
                check_output($sformatf("pkg_legal o%0d s%0d", off, size),
                             64'(rx_transfer_illegal(BYTES, off, size, BOUND)),
                             64'(model_err(off, size)));
            end
        end

        // Single legal transfer on ch0
        apply_stimulus(0, 1'b1, 0, 4, 32'hAABB_CCDD);
        #1;
        check_output("legal ready", 64'(md_rx_ready), 64'b01);
        check_output("legal err", 64'(md_rx_err), 64'b00);
        next_cycle();
        apply_stimulus(0, 1'b0, 0, 0, 32'h0);
        check_output("legal push_valid", 64'(push_valid), 64'd1);
        check_output("legal push_data", 64'(push_data), 64'(pack(0, 4, 0, 32'hAABB_CCDD)));

        // Table-driven legality vectors on ch1, push_ready held high
        ecnt = 0;
        for (int i = 0; i < 11; i++) begin
            apply_stimulus(1, tbl[i].valid, tbl[i].off, tbl[i].size, tbl[i].data);
            #1;
            check_output($sformatf("tbl%0d err", i), 64'(md_rx_err[1]), 64'(tbl[i].exp_err));
            check_output($sformatf("tbl%0d ready", i), 64'(md_rx_ready[1]), 64'(tbl[i].exp_ready));
            if (tbl[i].exp_err && ecnt < CMAX) ecnt++;
            next_cycle();
            apply_stimulus(1, 1'b0, 0, 0, 32'h0);
            check_output($sformatf("tbl%0d push_valid", i), 64'(push_valid),
                         64'(tbl[i].valid && !tbl[i].exp_err));
            if (tbl[i].valid && !tbl[i].exp_err)
                check_output($sformatf("tbl%0d push_data", i), 64'(push_data),
                             64'(pack(1, tbl[i].size, tbl[i].off, tbl[i].data)));
            check_output($sformatf("tbl%0d cnt1", i), 64'(status_cnt_drop[CW +: CW]), 64'(ecnt));
        end

        // Saturation then clear-beats-increment on ch0
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(0, 1'b1, 0, 0, 32'h0);
            next_cycle();
            check_output($sformatf("sat cnt0 step%0d", i), 64'(status_cnt_drop[0 +: CW]),
                         64'((i + 1 < CMAX) ? i + 1 : CMAX));
        end
        clr_cnt_drop = 2'b11;
        next_cycle();
        clr_cnt_drop = 2'b00;
        apply_stimulus(0, 1'b0, 0, 0, 32'h0);
        check_output("clear cnt0", 64'(status_cnt_drop[0 +: CW]), 64'd0);
        check_output("clear cnt1", 64'(status_cnt_drop[CW +: CW]), 64'd0);

        // Backpressure: hold the stage, illegal ch1 still acked and counted
        apply_stimulus(0, 1'b1, 0, 4, 32'hD1D1_D1D1);
        #1;
        check_output("bp accept ready", 64'(md_rx_ready), 64'b01);
        next_cycle();
        held = pack(0, 4, 0, 32'hD1D1_D1D1);
        push_ready = 1'b0;
        apply_stimulus(0, 1'b1, 2, 2, 32'hD2D2_D2D2);
        apply_stimulus(1, 1'b1, 0, 0, 32'hEEEE_EEEE);
        for (int i = 0; i < 5; i++) begin
            #1;
            check_output($sformatf("bp%0d ready", i), 64'(md_rx_ready), 64'b10);
            next_cycle();
            check_output($sformatf("bp%0d push_valid", i), 64'(push_valid), 64'd1);
            check_output($sformatf("bp%0d push_data", i), 64'(push_data), 64'(held));
        end
        check_output("bp cnt1", 64'(status_cnt_drop[CW +: CW]), 64'(CMAX));
        apply_stimulus(1, 1'b0, 0, 0, 32'h0);
        push_ready = 1'b1;
        #1;
        check_output("bp release ready", 64'(md_rx_ready), 64'b01);
        next_cycle();
        apply_stimulus(0, 1'b0, 0, 0, 32'h0);
        check_output("bp release push_valid", 64'(push_valid), 64'd1);
        check_output("bp release push_data", 64'(push_data), 64'(pack(0, 2, 2, 32'hD2D2_D2D2)));
        next_cycle();
        check_output("bp drained", 64'(push_valid), 64'd0);

        // Reset while the stage holds a transfer
        push_ready = 1'b0;
        apply_stimulus(0, 1'b1, 0, 4, 32'hD4D4_D4D4);
        next_cycle();
        apply_stimulus(0, 1'b0, 0, 0, 32'h0);
        check_output("pre-reset push_valid", 64'(push_valid), 64'd1);
        #1;
        preset_n = 1'b0;
        #1;
        check_output("mid reset push_valid", 64'(push_valid), 64'd0);
        check_output("mid reset push_data", 64'(push_data), 64'd0);
        check_output("mid reset counters", 64'(status_cnt_drop), 64'd0);
        @(negedge pclk);
        preset_n = 1'b1;
        push_ready = 1'b1;
        next_cycle();

        // Fairness: both legal continuously, grants alternate starting at ch0
        d[0] = 32'hA000_0000;
        d[1] = 32'hB000_0000;
        apply_stimulus(0, 1'b1, 0, 4, d[0]);
        apply_stimulus(1, 1'b1, 0, 4, d[1]);
        for (int i = 0; i < 4; i++) begin
            exp_ch = i % 2;
            #1;
            check_output($sformatf("fair%0d ready", i), 64'(md_rx_ready), 64'(2'b01 << exp_ch));
            next_cycle();
            check_output($sformatf("fair%0d push_data", i), 64'(push_data),
                         64'(pack(exp_ch, 4, 0, d[exp_ch])));
            d[exp_ch] = d[exp_ch] + 32'd1;
            apply_stimulus(exp_ch, 1'b1, 0, 4, d[exp_ch]);
        end

        // Randomized run against the behavioural model
        pulse_reset();
        m_pv   = 1'b0;
        m_pd   = '0;
        m_last = NCH - 1;
        for (int c = 0; c < NCH; c++) begin
            pend[c]  = 1'b0;
            m_cnt[c] = 0;
        end
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int c = 0; c < NCH; c++) begin
                if (!pend[c]) begin
                    r_v[c]    = ($urandom_range(0, 99) < 65);
                    r_off[c]  = int'($urandom_range(0, 3));
                    r_size[c] = int'($urandom_range(0, 7));
                    r_data[c] = $urandom;
                    apply_stimulus(c, r_v[c], r_off[c], r_size[c], r_data[c]);
                end
                clr_cnt_drop[c] = ($urandom_range(0, 19) == 0);
            end
            push_ready = ($urandom_range(0, 9) < 7);
            #1;
            for (int c = 0; c < NCH; c++) begin
                e_err[c]   = r_v[c] && model_err(r_off[c], r_size[c]);
                e_legal[c] = r_v[c] && !e_err[c];
            end
            load = !m_pv || push_ready;
            g = rr_pick(e_legal, m_last);
            for (int c = 0; c < NCH; c++)
                e_ready[c] = e_err[c] || (load && g == c);
            check_output("rnd err", 64'(md_rx_err), 64'(e_err));
            check_output("rnd ready", 64'(md_rx_ready), 64'(e_ready));
            next_cycle();
            for (int c = 0; c < NCH; c++) begin
                if (clr_cnt_drop[c]) m_cnt[c] = 0;
                else if (e_err[c] && m_cnt[c] < CMAX) m_cnt[c]++;
                pend[c] = r_v[c] && !e_ready[c];
            end
            if (load && g >= 0) begin
                m_pv   = 1'b1;
                m_pd   = pack(g, r_size[g], r_off[g], r_data[g]);
                m_last = g;
            end else if (push_ready) begin
                m_pv = 1'b0;
            end
            check_output("rnd push_valid", 64'(push_valid), 64'(m_pv));
            if (m_pv)
                check_output("rnd push_data", 64'(push_data), 64'(m_pd));
            check_output("rnd counters", 64'(status_cnt_drop), 64'({2'(m_cnt[1]), 2'(m_cnt[0])}));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cfs_rx_ctrl_mc.md
Name: cfs_rx_ctrl_mc

Overview:
Multi-channel MD RX controller: the next generation of the single-channel RX controller.
- Accepts NUM_CH independent MD RX request streams and checks each for alignment legality.
- Acknowledges and counts illegal transfers per channel.
- Round-robin arbitrates legal transfers into one registered push interface toward the RX FIFO.
- Single clock domain (pclk). Drop counters are native to pclk, so no synchroniser is needed.

Parameters:
- NUM_CH, 2: number of MD RX channels (1..16).
- ALGN_DATA_WIDTH, 32: data width in bits; BYTES = ALGN_DATA_WIDTH/8.
- STATUS_CNT_DROP_WIDTH, 8: width of each per-channel drop counter.
- Derived, not overridable:
  - CH_WIDTH = max(1, clog2(NUM_CH)).
  - OFFSET_W = BYTES<=1 ? 1 : clog2(BYTES).
  - SIZE_W = clog2(BYTES)+1.
  - FIFO_DATA_WIDTH = CH_WIDTH + SIZE_W + OFFSET_W + ALGN_DATA_WIDTH.

Ports:
- pclk  in  1  clock.
- preset_n  in  1  asynchronous active-low reset.
- clr_cnt_drop  in  NUM_CH  per-channel synchronous counter clear.
- status_cnt_drop  out  NUM_CH*STATUS_CNT_DROP_WIDTH  packed drop counters; channel c occupies slice [c*W +: W].
- md_rx_valid  in  NUM_CH  per-channel request.
- md_rx_data  in  NUM_CH*ALGN_DATA_WIDTH  packed data.
- md_rx_offset  in  NUM_CH*OFFSET_W  packed offset.
- md_rx_size  in  NUM_CH*SIZE_W  packed size.
- md_rx_ready  out  NUM_CH  per-channel acknowledge.
- md_rx_err  out  NUM_CH  per-channel illegal flag.
- push_valid  out  1  output stage holds a transfer.
- push_data  out  FIFO_DATA_WIDTH  {ch, size, offset, data}, MSB to LSB.
- push_ready  in  1  FIFO accepts.

Behaviour:
- Reset (async, preset_n=0):
  - push_valid=0, push_data=0.
  - All counters = 0.
  - Arbiter pointer = NUM_CH-1, so channel 0 has first priority.
  - Reset mid-transfer discards the output stage contents.
- md_rx_err[c] is combinational and 0 when md_rx_valid[c]=0. It is 1 when valid and:
  - size==0, or
  - (BYTES+offset) % size != 0.
  - Evaluate the arithmetic in SIZE_W+1 bits so there is no truncation.
- Illegal channel: md_rx_ready[c]=1 in the same cycle, independent of arbitration and of push_ready. Nothing is pushed.
- Drop counter:
  - Increments on valid & ready & err.
  - Saturates at 2^W-1 with no wrap.
  - clr_cnt_drop[c] zeroes it on the next edge.
  - Clear beats an increment in the same cycle.
- Legal candidate: valid & !err.
- Grant:
  - Search begins at pointer+1 and wraps at NUM_CH-1 back to 0.
  - The first candidate found is granted.
  - At most one grant per cycle.
- Load condition: load = !push_valid | push_ready.
  - The granted channel gets md_rx_ready=1 only when load=1.
  - Non-granted legal channels get ready=0.
- On acceptance (granted & load):
  - The output register captures {grant_idx, size, offset, data}.
  - push_valid=1 on the next cycle (latency 1).
  - The pointer updates to grant_idx.
- The pointer is unchanged when there is no acceptance.
- push_valid & push_ready with no new acceptance: push_valid=0 next cycle.
- push_valid & push_ready with a new acceptance in the same cycle: back-to-back, so throughput is 1 transfer per cycle.
- push_valid & !push_ready:
  - push_data holds stable.
  - No legal channel is acked.
  - Illegal channels are still acked and counted.
- A channel may change its request only after it is acked. The block does not check this.

Optional Feature:
- Macro: CFS_RX_CTRL_MC_SIZE_BOUND_EN.
- Defined: md_rx_err is additionally 1 when offset+size > BYTES, i.e. the transfer spans past the data word.
- Undefined: only the size==0 and modulo rules apply.
- No port changes in either case.

Decomposition:
- Shared package cfs_rx_ctrl_pkg holds:
  - Width functions (offset, size and channel widths).
  - The push_data field LSB/MSB constants.
  - The legality check function, used by RTL and by the scoreboard.
- Sub-module cfs_rr_arbiter:
  - Parameter NUM_CH.
  - Inputs req, advance.
  - Outputs grant_onehot, grant_idx.
  - Owns the pointer register, reset to NUM_CH-1.

Test Plan (NUM_CH=2, ALGN_DATA_WIDTH=32, STATUS_CNT_DROP_WIDTH=8 unless stated):
- Legal transfer: ch0 valid, offset=0, size=4, data=0xAABBCCDD, push_ready=1 -> ch0 ready in the same cycle; next cycle push_valid=1 with {ch=0, size=4, offset=0, 0xAABBCCDD}.
- Illegal patterns: ch1 sends size=0, then offset=1/size=2, then offset=3/size=2 -> each acked in the same cycle with err=1; no push; cnt[1]=3. Then offset=2/size=2 and offset=3/size=1 -> both legal and pushed.
- Fairness: both channels held valid and legal, push_ready=1 -> grants go 0,1,0,1.
- Backpressure: push_ready=0 after one accept -> push_data stable for 5 cycles and ready=0 on both channels. Release -> next transfer is pushed the following cycle with no beat lost.
- Saturation and clear (STATUS_CNT_DROP_WIDTH=2): 5 illegal transfers -> cnt=3. clr_cnt_drop asserted together with an illegal transfer -> cnt=0.
- Macro and reset:
  - offset=2/size=3 -> err only when CFS_RX_CTRL_MC_SIZE_BOUND_EN is defined.
  - preset_n dropped while push_valid=1 -> push_valid=0 and counters 0 immediately; ch0 is granted first after release.
